// File: rtl/alu_share_pkg.sv
// Shared definitions for the ALU-sharing controller: control codes, FSM states
// and the legal-opcode check used to flag unsupported operations.
package alu_share_pkg;

  localparam int ALU_W = 32;

  localparam logic [3:0] CTRL_AND = 4'b0000;
  localparam logic [3:0] CTRL_OR  = 4'b0001;
  localparam logic [3:0] CTRL_ADD = 4'b0010;
  localparam logic [3:0] CTRL_SUB = 4'b0110;
  localparam logic [3:0] CTRL_SLT = 4'b0111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic logic is_legal_ctrl(input logic [3:0] ctrl);
    case (ctrl)
      CTRL_AND, CTRL_OR, CTRL_ADD, CTRL_SUB, CTRL_SLT: return 1'b1;
      default:                                         return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_share_alu.sv
// Existing shared 32-bit combinational ALU. Codes it does not implement
// produce a don't-care value; the controller masks those.
module alu_share_alu (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [3:0]  ctrl_i,
  output logic [31:0] y_o
);

  always_comb begin
    case (ctrl_i)
      4'b0000: y_o = a_i & b_i;
      4'b0001: y_o = a_i | b_i;
      4'b0010: y_o = a_i + b_i;
      4'b0110: y_o = a_i - b_i;
      4'b0111: y_o = {31'd0, a_i < b_i};
      default: y_o = a_i ^ b_i;
    endcase
  end

endmodule

// File: rtl/alu_share_rr_grant.sv
// Grant selector: round-robin starting after last_i, or lowest-index fixed
// priority (no pointer input) when ALU_SHARE_FIXED_PRIO_EN is defined.
module rr_grant #(
  parameter  int NUM_REQ = 2,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
`ifndef ALU_SHARE_FIXED_PRIO_EN
  input  logic [IDX_W-1:0]   last_i,
`endif
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  assign any_o = |req_i;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
`ifdef ALU_SHARE_FIXED_PRIO_EN
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        gnt_o    = '0;
        gnt_o[i] = 1'b1;
        idx_o    = IDX_W'(i);
      end
    end
`else
    // Walk from the farthest offset down so the nearest candidate after last wins.
    for (int off = NUM_REQ; off >= 1; off--) begin
      if (req_i[(int'(last_i) + off) % NUM_REQ]) begin
        gnt_o = '0;
        gnt_o[(int'(last_i) + off) % NUM_REQ] = 1'b1;
        idx_o = IDX_W'((int'(last_i) + off) % NUM_REQ);
      end
    end
`endif
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Arbitrated front-end sharing one 32-bit ALU among NUM_REQ requesters.
// Define ALU_SHARE_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module alu_share_ctrl
  import alu_share_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = ALU_W
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  input  logic [NUM_REQ*DATA_W-1:0] req_src1_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_src2_i,
  input  logic [NUM_REQ*4-1:0]      req_ctrl_i,
  output logic [NUM_REQ-1:0]        rsp_valid_o,
  input  logic [NUM_REQ-1:0]        rsp_ready_i,
  output logic [DATA_W-1:0]         rsp_result_o,
  output logic                      rsp_zero_o,
  output logic                      rsp_err_o,
  output logic                      busy_o
);

  localparam int IDX_W = $clog2(NUM_REQ);

  if (DATA_W != ALU_W) begin : g_bad_data_w
    $error("alu_share_ctrl: DATA_W must be %0d", ALU_W);
  end
  if (NUM_REQ < 2 || NUM_REQ > 4) begin : g_bad_num_req
    $error("alu_share_ctrl: NUM_REQ must be 2..4");
  end

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   src1_q, src1_d, src2_q, src2_d;
  logic [3:0]          ctrl_q, ctrl_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic                zero_q, zero_d, err_q, err_d, busy_q, busy_d;
  logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;

  logic [NUM_REQ-1:0]  gnt;
  logic [IDX_W-1:0]    gnt_idx;
  logic                gnt_any, grant_en;
  logic [DATA_W-1:0]   alu_y, op_result;
  logic                op_err;

`ifndef ALU_SHARE_FIXED_PRIO_EN
  logic [IDX_W-1:0]    ptr_q, ptr_d;
`endif

  rr_grant #(.NUM_REQ(NUM_REQ)) u_grant (
    .req_i  (req_valid_i),
`ifndef ALU_SHARE_FIXED_PRIO_EN
    .last_i (ptr_q),
`endif
    .gnt_o  (gnt),
    .idx_o  (gnt_idx),
    .any_o  (gnt_any)
  );

  alu_share_alu u_alu (
    .a_i    (src1_q),
    .b_i    (src2_q),
    .ctrl_i (ctrl_q),
    .y_o    (alu_y)
  );

  // Unsupported codes never expose whatever the ALU computed for them.
  assign op_err    = !is_legal_ctrl(ctrl_q);
  assign op_result = op_err ? '0 : alu_y;

  always_comb begin
    state_d     = state_q;
    src1_d      = src1_q;
    src2_d      = src2_q;
    ctrl_d      = ctrl_q;
    owner_d     = owner_q;
    result_d    = result_q;
    zero_d      = zero_q;
    err_d       = err_q;
    rsp_valid_d = rsp_valid_q;
    grant_en    = 1'b0;
`ifndef ALU_SHARE_FIXED_PRIO_EN
    ptr_d       = ptr_q;
`endif

    case (state_q)
      ST_IDLE: grant_en = 1'b1;
      ST_EXEC: begin
        result_d             = op_result;
        zero_d               = (op_result == '0);
        err_d                = op_err;
        rsp_valid_d          = '0;
        rsp_valid_d[owner_q] = 1'b1;
        state_d              = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready_i[owner_q]) begin
          rsp_valid_d = '0;
          state_d     = ST_IDLE;
          grant_en    = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (grant_en && gnt_any) begin
      src1_d  = req_src1_i[int'(gnt_idx)*DATA_W +: DATA_W];
      src2_d  = req_src2_i[int'(gnt_idx)*DATA_W +: DATA_W];
      ctrl_d  = req_ctrl_i[int'(gnt_idx)*4 +: 4];
      owner_d = gnt_idx;
      state_d = ST_EXEC;
`ifndef ALU_SHARE_FIXED_PRIO_EN
      ptr_d   = gnt_idx;
`endif
    end

    busy_d = (state_d != ST_IDLE);
  end

  // Gated by reset so no accept is signalled while the block is held in reset.
  assign req_ready_o = (rst_i && grant_en) ? gnt : '0;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= ST_IDLE;
      src1_q      <= '0;
      src2_q      <= '0;
      ctrl_q      <= '0;
      owner_q     <= '0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      rsp_valid_q <= '0;
`ifndef ALU_SHARE_FIXED_PRIO_EN
      ptr_q       <= IDX_W'(NUM_REQ - 1);
`endif
    end else begin
      state_q     <= state_d;
      src1_q      <= src1_d;
      src2_q      <= src2_d;
      ctrl_q      <= ctrl_d;
      owner_q     <= owner_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
`ifndef ALU_SHARE_FIXED_PRIO_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_result_o = result_q;
  assign rsp_zero_o   = zero_q;
  assign rsp_err_o    = err_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed self-checking bench for alu_share_ctrl (NUM_REQ = 2, round-robin build).
module tb_alu_share_ctrl;

  logic        clk_i;
  logic        rst_i;
  logic [1:0]  req_valid_i;
  logic [1:0]  req_ready_o;
  logic [63:0] req_src1_i;
  logic [63:0] req_src2_i;
  logic [7:0]  req_ctrl_i;
  logic [1:0]  rsp_valid_o;
  logic [1:0]  rsp_ready_i;
  logic [31:0] rsp_result_o;
  logic        rsp_zero_o;
  logic        rsp_err_o;
  logic        busy_o;

  int n_vec = 0;
  int n_err = 0;

  alu_share_ctrl #(.NUM_REQ(2), .DATA_W(32)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_src1_i   (req_src1_i),
    .req_src2_i   (req_src2_i),
    .req_ctrl_i   (req_ctrl_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_result_o (rsp_result_o),
    .rsp_zero_o   (rsp_zero_o),
    .rsp_err_o    (rsp_err_o),
    .busy_o       (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next falling edge, well away from the active edge.
  task automatic nxt();
    @(negedge clk_i);
    #1;
  endtask

  task automatic set_req(input int r, input logic v, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] c);
    req_valid_i[r]        = v;
    req_src1_i[r*32 +: 32] = a;
    req_src2_i[r*32 +: 32] = b;
    req_ctrl_i[r*4 +: 4]   = c;
  endtask

  // One isolated operation from IDLE with rsp_ready_i = 11.
  task automatic do_op(input int r, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] c, input logic [31:0] er, input logic ez,
                       input logic ee, input string tag);
    logic [1:0] oh;
    oh = 2'b01 << r;
    set_req(r, 1'b1, a, b, c);
    #1;
    chk({tag, " grant"}, 32'(req_ready_o), 32'(oh));
    nxt();
    set_req(r, 1'b0, a, b, c);
    chk({tag, " exec rsp_valid"}, 32'(rsp_valid_o), 32'd0);
    chk({tag, " exec busy"}, 32'(busy_o), 32'd1);
    chk({tag, " exec ready"}, 32'(req_ready_o), 32'd0);
    nxt();
    chk({tag, " rsp_valid"}, 32'(rsp_valid_o), 32'(oh));
    chk({tag, " result"}, rsp_result_o, er);
    chk({tag, " zero"}, 32'(rsp_zero_o), 32'(ez));
    chk({tag, " err"}, 32'(rsp_err_o), 32'(ee));
    $display("op %s: req%0d a=%08h b=%08h ctrl=%b -> result=%08h zero=%b err=%b",
             tag, r, a, b, c, rsp_result_o, rsp_zero_o, rsp_err_o);
    nxt();
    chk({tag, " idle busy"}, 32'(busy_o), 32'd0);
  endtask

  int ord[4] = '{1, 0, 1, 0};

  initial begin
    rst_i       = 1'b0;
    req_valid_i = '0;
    req_src1_i  = '0;
    req_src2_i  = '0;
    req_ctrl_i  = '0;
    rsp_ready_i = 2'b11;

    // Reset state, with a request pending that must not be accepted.
    set_req(0, 1'b1, 32'd1, 32'd1, 4'b0010);
    nxt();
    nxt();
    chk("reset ready", 32'(req_ready_o), 32'd0);
    chk("reset rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("reset result", rsp_result_o, 32'd0);
    chk("reset zero", 32'(rsp_zero_o), 32'd0);
    chk("reset err", 32'(rsp_err_o), 32'd0);
    chk("reset busy", 32'(busy_o), 32'd0);
    set_req(0, 1'b0, 32'd0, 32'd0, 4'b0000);
    rst_i = 1'b1;
    nxt();

    do_op(0, 32'd5, 32'd7, 4'b0010, 32'd12, 1'b0, 1'b0, "add");

    // Contention: last grant was requester 0, so requester 1 goes first.
    set_req(0, 1'b1, 32'd1, 32'd1, 4'b0010);
    set_req(1, 1'b1, 32'd2, 32'd2, 4'b0010);
    #1;
    chk("rr grant 0", 32'(req_ready_o), 32'd2);
    for (int i = 0; i < 4; i++) begin
      nxt();
      chk("rr exec ready", 32'(req_ready_o), 32'd0);
      nxt();
      chk("rr rsp_valid", 32'(rsp_valid_o), 32'd1 << ord[i]);
      chk("rr result", rsp_result_o, (ord[i] == 1) ? 32'd4 : 32'd2);
      $display("rr op %0d: owner req%0d result=%08h", i, ord[i], rsp_result_o);
      if (i < 3) begin
        chk("rr next grant", 32'(req_ready_o), 32'd1 << ord[i+1]);
      end else begin
        set_req(0, 1'b0, 32'd0, 32'd0, 4'b0000);
        set_req(1, 1'b0, 32'd0, 32'd0, 4'b0000);
      end
    end
    nxt();
    chk("rr idle busy", 32'(busy_o), 32'd0);

    do_op(0, 32'd9, 32'd9, 4'b0110, 32'd0, 1'b1, 1'b0, "sub_zero");
    do_op(0, 32'd0, 32'd1, 4'b0110, 32'hFFFF_FFFF, 1'b0, 1'b0, "sub_wrap");

    // Backpressure on requester 1; the non-owner ready bit is held high meanwhile.
    rsp_ready_i = 2'b01;
    set_req(1, 1'b1, 32'd3, 32'd8, 4'b0111);
    #1;
    chk("bp grant", 32'(req_ready_o), 32'd2);
    nxt();
    set_req(1, 1'b0, 32'd0, 32'd0, 4'b0000);
    set_req(0, 1'b1, 32'd10, 32'd20, 4'b0010);
    #1;
    chk("bp exec ready", 32'(req_ready_o), 32'd0);
    for (int k = 0; k < 4; k++) begin
      nxt();
      chk("bp rsp_valid", 32'(rsp_valid_o), 32'd2);
      chk("bp result held", rsp_result_o, 32'd1);
      chk("bp no grant", 32'(req_ready_o), 32'd0);
    end
    nxt();
    rsp_ready_i = 2'b10;
    #1;
    chk("bp handshake grant", 32'(req_ready_o), 32'd1);
    chk("bp handshake result", rsp_result_o, 32'd1);
    $display("bp op: owner req1 SLT result=%08h", rsp_result_o);
    nxt();
    set_req(0, 1'b0, 32'd0, 32'd0, 4'b0000);
    rsp_ready_i = 2'b11;
    chk("b2b exec rsp_valid", 32'(rsp_valid_o), 32'd0);
    nxt();
    chk("b2b rsp_valid", 32'(rsp_valid_o), 32'd1);
    chk("b2b result", rsp_result_o, 32'd30);
    $display("b2b op: owner req0 ADD result=%08h", rsp_result_o);
    nxt();
    chk("b2b idle busy", 32'(busy_o), 32'd0);

    do_op(1, 32'h12, 32'h34, 4'b1111, 32'd0, 1'b1, 1'b1, "illegal");
    do_op(0, 32'hF0, 32'h0F, 4'b0001, 32'hFF, 1'b0, 1'b0, "or");

    // Reset during EXEC: everything clears at once, and the pointer restarts at req0.
    set_req(0, 1'b1, 32'd5, 32'd7, 4'b0010);
    #1;
    chk("rst grant", 32'(req_ready_o), 32'd1);
    nxt();
    set_req(0, 1'b0, 32'd0, 32'd0, 4'b0000);
    chk("rst exec busy", 32'(busy_o), 32'd1);
    rst_i = 1'b0;
    set_req(0, 1'b1, 32'hFF, 32'h0F, 4'b0000);
    set_req(1, 1'b1, 32'd1, 32'd2, 4'b0010);
    #1;
    chk("rst async result", rsp_result_o, 32'd0);
    chk("rst async zero", 32'(rsp_zero_o), 32'd0);
    chk("rst async err", 32'(rsp_err_o), 32'd0);
    chk("rst async busy", 32'(busy_o), 32'd0);
    chk("rst async rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("rst async ready", 32'(req_ready_o), 32'd0);
    nxt();
    nxt();
    chk("rst no response", 32'(rsp_valid_o), 32'd0);
    rst_i = 1'b1;
    #1;
    chk("post rst grant", 32'(req_ready_o), 32'd1);
    nxt();
    set_req(0, 1'b0, 32'd0, 32'd0, 4'b0000);
    set_req(1, 1'b0, 32'd0, 32'd0, 4'b0000);
    nxt();
    chk("post rst rsp_valid", 32'(rsp_valid_o), 32'd1);
    chk("post rst result", rsp_result_o, 32'h0F);
    $display("post-reset op: owner req0 AND result=%08h", rsp_result_o);
    nxt();
    chk("post rst idle", 32'(busy_o), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
